edge_event_arbiter: RTL and testbench

Multi-channel edge-event scheduler for the level-to-pulse path. It edge-detects N level inputs, holds one pending event per channel, and round-robin serializes them onto a single valid/ready event stream tagged with channel id and edge type. It sits between synchronized status/level sources and the single consumer (interrupt/event logger) that cannot take simultaneous pulses.

---
 rtl/edge_event_arbiter.sv | 132 +++++++++++++
 tb/tb_edge_event_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// Edge-detects N synchronous level inputs, keeps one pending event per channel and
// round-robin serializes them onto a valid/ready stream. Optional macro: EDGE_ARB_DROP_CNT_EN.
module edge_event_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    level_in,
    input  logic [N-1:0]    rise_en,
    input  logic [N-1:0]    fall_en,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [ID_W-1:0] evt_id,
    output logic            evt_edge,
    output logic            drop
`ifdef EDGE_ARB_DROP_CNT_EN
    ,
    output logic [7:0]      drop_cnt,
    input  logic            drop_clr
`endif
);

    localparam int unsigned CNT_W = 8;

    logic [N-1:0]    prev;
    logic [N-1:0]    pend;
    logic [N-1:0]    pend_edge;
    logic [ID_W-1:0] ptr;

    logic [N-1:0]    rise_c;
    logic [N-1:0]    fall_c;
    logic [N-1:0]    pend_nxt;
    logic [N-1:0]    pend_edge_nxt;
    logic            free_c;
    logic            found_c;
    logic [ID_W-1:0] grant_c;
    logic [ID_W-1:0] ptr_nxt;
    logic            drop_nxt;
    int unsigned     idx_c;

    assign rise_c = level_in & ~prev & rise_en;
    assign fall_c = ~level_in & prev & fall_en;
    assign free_c = ~evt_valid | evt_ready;

    // Round-robin search over registered pend, starting at ptr and wrapping at N-1.
    always_comb begin
        found_c = 1'b0;
        grant_c = '0;
        idx_c   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx_c = 32'(ptr) + k;
            if (idx_c >= N) begin
                idx_c = idx_c - N;
            end
            if (!found_c && pend[ID_W'(idx_c)]) begin
                found_c = 1'b1;
                grant_c = ID_W'(idx_c);
            end
        end
    end

    assign ptr_nxt = (grant_c == ID_W'(N - 1)) ? '0 : grant_c + ID_W'(1);

    // Slot update: a slot being granted this cycle can absorb a new edge; otherwise the newest edge is lost.
    always_comb begin
        pend_nxt      = pend;
        pend_edge_nxt = pend_edge;
        drop_nxt      = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (rise_c[i] || fall_c[i]) begin
                if (!pend[i] || (free_c && found_c && grant_c == ID_W'(i))) begin
                    pend_nxt[i]      = 1'b1;
                    pend_edge_nxt[i] = rise_c[i];
                end else begin
                    drop_nxt = 1'b1;
                end
            end else if (free_c && found_c && grant_c == ID_W'(i)) begin
                pend_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev      <= '0;
            pend      <= '0;
            pend_edge <= '0;
            ptr       <= '0;
            drop      <= 1'b0;
        end else begin
            prev      <= level_in;
            pend      <= pend_nxt;
            pend_edge <= pend_edge_nxt;
            drop      <= drop_nxt;
            if (free_c && found_c) begin
                ptr <= ptr_nxt;
            end
        end
    end

    // Output stage holds every field while a presented event is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_edge  <= 1'b0;
        end else if (free_c) begin
            if (found_c) begin
                evt_valid <= 1'b1;
                evt_id    <= grant_c;
                evt_edge  <= pend_edge[grant_c];
            end else begin
                evt_valid <= 1'b0;
            end
        end
    end

`ifdef EDGE_ARB_DROP_CNT_EN
    // Saturating count of cycles with a drop pulse; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_clr) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with hand-computed expectations.
// Covers the drop counter too when EDGE_ARB_DROP_CNT_EN is defined.
module tb_edge_event_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned ID_W = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    level_in = '0;
    logic [N-1:0]    rise_en = '1;
    logic [N-1:0]    fall_en = '1;
    logic            evt_valid;
    logic            evt_ready = 1'b1;
    logic [ID_W-1:0] evt_id;
    logic            evt_edge;
    logic            drop;
`ifdef EDGE_ARB_DROP_CNT_EN
    logic [7:0]      drop_cnt;
    logic            drop_clr = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    edge_event_arbiter #(.N(N), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .level_in  (level_in),
        .rise_en   (rise_en),
        .fall_en   (fall_en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_edge  (evt_edge),
        .drop      (drop)
`ifdef EDGE_ARB_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt),
        .drop_clr  (drop_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_evt(input string tag, input logic v, input logic [ID_W-1:0] id, input logic e);
        check({tag, "_valid"}, 8'(evt_valid), 8'(v));
        if (v) begin
            check({tag, "_id"}, 8'(evt_id), 8'(id));
            check({tag, "_edge"}, 8'(evt_edge), 8'(e));
        end
    endtask

    task automatic do_reset(input logic [N-1:0] lvl);
        rst_n    = 1'b0;
        level_in = lvl;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset('0);
        check("rst_valid", 8'(evt_valid), 8'd0);
        check("rst_drop", 8'(drop), 8'd0);
`ifdef EDGE_ARB_DROP_CNT_EN
        check("rst_cnt", drop_cnt, 8'd0);
`endif
        tick();
        tick();

        // Single rise on ch2: two-cycle latency, one-cycle event
        level_in = 4'b0100;
        tick();
        check_evt("t1_c1", 1'b0, 2'd0, 1'b0);
        tick();
        check_evt("t1_c2", 1'b1, 2'd2, 1'b1);
        check("t1_drop", 8'(drop), 8'd0);
        tick();
        check_evt("t1_c3", 1'b0, 2'd0, 1'b0);
        level_in = 4'b0000;
        tick();
        tick();
        check_evt("t1_fall", 1'b1, 2'd2, 1'b0);
        tick();
        check_evt("t1_idle", 1'b0, 2'd0, 1'b0);

        // Simultaneous rises on all channels drain in id order
        do_reset('0);
        level_in = 4'b1111;
        tick();
        check_evt("t2_c1", 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_evt("t2_burst", 1'b1, ID_W'(i), 1'b1);
        end
        tick();
        check_evt("t2_end", 1'b0, 2'd0, 1'b0);

        // Backpressure: held output, second rise dropped, oldest kept
        do_reset('0);
        evt_ready = 1'b0;
        level_in  = 4'b0010;
        tick();
        tick();
        check_evt("t3_first", 1'b1, 2'd1, 1'b1);
        tick();
        level_in = 4'b0000;
        tick();
        check_evt("t3_hold1", 1'b1, 2'd1, 1'b1);
        tick();
        tick();
        level_in = 4'b0010;
        tick();
        check("t3_drop", 8'(drop), 8'd1);
        check_evt("t3_hold2", 1'b1, 2'd1, 1'b1);
        tick();
        check("t3_drop_end", 8'(drop), 8'd0);
`ifdef EDGE_ARB_DROP_CNT_EN
        check("t3_cnt", drop_cnt, 8'd1);
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        check("t3_clr", drop_cnt, 8'd0);
`endif
        evt_ready = 1'b1;
        tick();
        check_evt("t3_pend", 1'b1, 2'd1, 1'b0);
        tick();
        check_evt("t3_done", 1'b0, 2'd0, 1'b0);
        tick();
        check_evt("t3_quiet", 1'b0, 2'd0, 1'b0);

        // Fairness: ch0 toggles while ch3 waits one grant
        do_reset('0);
        level_in = 4'b1001;
        tick();
        check_evt("t4_c1", 1'b0, 2'd0, 1'b0);
        level_in = 4'b1000;
        tick();
        check_evt("t4_g0", 1'b1, 2'd0, 1'b1);
        level_in = 4'b1001;
        tick();
        check_evt("t4_g3", 1'b1, 2'd3, 1'b1);
        check("t4_drop", 8'(drop), 8'd1);
        tick();
        check_evt("t4_g0b", 1'b1, 2'd0, 1'b0);
        check("t4_drop_end", 8'(drop), 8'd0);
        tick();
        check_evt("t4_end", 1'b0, 2'd0, 1'b0);

        // Masks: falls on ch0 suppressed; enable change keeps pending event
        do_reset('0);
        fall_en = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            level_in[0] = ~level_in[0];
            tick();
            tick();
            check_evt("t5_toggle", (k % 2) == 0, 2'd0, 1'b1);
            tick();
            check_evt("t5_gap", 1'b0, 2'd0, 1'b0);
        end
        level_in[0] = 1'b1;
        tick();
        rise_en = '0;
        fall_en = '0;
        tick();
        check_evt("t5_kept", 1'b1, 2'd0, 1'b1);
        rise_en = '1;
        fall_en = '1;
        tick();
        check_evt("t5_end", 1'b0, 2'd0, 1'b0);

        // Asynchronous reset mid-operation
        do_reset('0);
        evt_ready = 1'b0;
        level_in  = 4'b1111;
        tick();
        tick();
        check_evt("t6_busy", 1'b1, 2'd0, 1'b1);
        level_in = 4'b0000;
        tick();
        check("t6_drop", 8'(drop), 8'd1);
        level_in = 4'b1111;
        rst_n    = 1'b0;
        #1;
        check("t6_rst_valid", 8'(evt_valid), 8'd0);
        check("t6_rst_drop", 8'(drop), 8'd0);
`ifdef EDGE_ARB_DROP_CNT_EN
        check("t6_rst_cnt", drop_cnt, 8'd0);
`endif
        tick();
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        tick();
        check_evt("t6_c1", 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_evt("t6_rise", 1'b1, ID_W'(i), 1'b1);
        end
        tick();
        check_evt("t6_end", 1'b0, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
